// File: rtl/uart_key_tx_feeder.sv
// Purpose : debounce four active-low keys, map each press to one byte, queue it, feed the UART tx.
// Latency : key_i fall -> tx_valid_o rise = DB_CYCLES + 4 edges (2 sync, debounce, arbiter write, show-ahead).
// Backpres: tx_ready_i low holds the head; presses arriving while the FIFO is full are dropped, ovf_o sticks.
//
// Ports
//   clk_i        system clock
//   rst_i        asynchronous reset, active-low
//   key_i        raw board keys, active-low, asynchronous to clk_i
//   tx_ready_i   transmitter accepts tx_data_o this cycle
//   tx_valid_o   FIFO head is valid (registered)
//   tx_data_o    FIFO head byte (registered)
//   key_state_o  debounced key levels, 1 = released
//   fifo_count_o entries currently held
//   ovf_o        sticky: a press was dropped because the FIFO was full
module uart_key_tx_feeder #(
    parameter int DATA_AMOUNT = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int DB_CYCLES   = 500000
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic [3:0]                      key_i,
    input  logic                            tx_ready_i,
    output logic                            tx_valid_o,
    output logic [DATA_AMOUNT-1:0]          tx_data_o,
    output logic [3:0]                      key_state_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count_o,
    output logic                            ovf_o
);

    localparam int PW     = $clog2(FIFO_DEPTH);
    localparam int CNTW   = PW + 1;
    localparam int DBW    = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int CODE_W = (DATA_AMOUNT > 8) ? DATA_AMOUNT : 8;

    localparam logic [DBW-1:0]  DB_LAST  = DBW'(DB_CYCLES - 1);
    localparam logic [CNTW-1:0] FULL_CNT = CNTW'(FIFO_DEPTH);

    // Synchronizer and debounce state
    logic [3:0]     sync1_q, sync2_q;
    logic [3:0]     key_state_q, key_state_d;
    logic [DBW-1:0] db_cnt_q [4];
    logic [DBW-1:0] db_cnt_d [4];
    logic [3:0]     press;

    // Press bookkeeping and arbitration
    logic [3:0]             pending_q, pending_d;
    logic [3:0]             clr_mask;
    logic                   win_vld;
    logic [1:0]             win_idx;
    logic [7:0]             code8;
    logic [CODE_W-1:0]      code_wide;
    logic [DATA_AMOUNT-1:0] win_dat;
    logic                   ovf_q, ovf_d;

    // FIFO
    logic [DATA_AMOUNT-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CNTW-1:0]        count_q, count_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [DATA_AMOUNT-1:0] tx_data_q, tx_data_d;
    logic                   pop, push, drop, full;

    always_comb begin
        // Debounce: any sample equal to the current state restarts the count.
        key_state_d = key_state_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != key_state_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    key_state_d[i] = sync2_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + DBW'(1);
                end
            end
        end
        // Only 1->0 transitions of the debounced level are presses.
        press = key_state_q & ~key_state_d;

        // Highest pending index wins.
        win_vld = |pending_q;
        win_idx = 2'd0;
        if (pending_q[3])      win_idx = 2'd3;
        else if (pending_q[2]) win_idx = 2'd2;
        else if (pending_q[1]) win_idx = 2'd1;

        case (win_idx)
            2'd3:    code8 = 8'h46;
            2'd2:    code8 = 8'h08;
            2'd1:    code8 = 8'h7F;
            default: code8 = 8'hFF;
        endcase
        code_wide = CODE_W'(code8);
        win_dat   = code_wide[DATA_AMOUNT-1:0];

        pop  = tx_valid_q & tx_ready_i;
        full = (count_q == FULL_CNT);
        // A full FIFO still accepts a write when its head leaves this cycle.
        push = win_vld & (~full | pop);
        drop = win_vld & full & ~pop;

        // The winner leaves the pending set whether written or dropped;
        // a fresh press on the same edge re-arms it.
        clr_mask = '0;
        if (win_vld) clr_mask[win_idx] = 1'b1;
        pending_d = (pending_q & ~clr_mask) | press;
        ovf_d     = ovf_q | drop;

        case ({push, pop})
            2'b10:   count_d = count_q + CNTW'(1);
            2'b01:   count_d = count_q - CNTW'(1);
            default: count_d = count_q;
        endcase
        rd_ptr_d = rd_ptr_q + PW'(pop);
        wr_ptr_d = wr_ptr_q + PW'(push);

        // Output stage ignores this cycle's push so a write into an empty
        // FIFO becomes visible one edge later; it never re-shows a popped head.
        tx_valid_d = ((count_q - CNTW'(pop)) != '0);
        tx_data_d  = tx_valid_d ? mem_q[rd_ptr_d] : tx_data_q;
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sync1_q     <= 4'hF;
            sync2_q     <= 4'hF;
            key_state_q <= 4'hF;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            pending_q   <= '0;
            ovf_q       <= 1'b0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
        end else begin
            sync1_q     <= key_i;
            sync2_q     <= sync1_q;
            key_state_q <= key_state_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            pending_q   <= pending_d;
            ovf_q       <= ovf_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
        end
    end

    // Storage needs no reset: entries are only read once count covers them.
    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= win_dat;
    end

    assign tx_valid_o   = tx_valid_q;
    assign tx_data_o    = tx_data_q;
    assign key_state_o  = key_state_q;
    assign fifo_count_o = count_q;
    assign ovf_o        = ovf_q;

endmodule

// File: tb/tb_uart_key_tx_feeder.sv
module tb_uart_key_tx_feeder;

    localparam int DW = 8;
    localparam int FD = 4;
    localparam int DB = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b0;
    logic [3:0]    key_i = 4'hF;
    logic          tx_ready_i = 1'b1;
    logic          tx_valid_o;
    logic [DW-1:0] tx_data_o;
    logic [3:0]    key_state_o;
    logic [2:0]    fifo_count_o;
    logic          ovf_o;

    int n_assert = 0;
    int n_fail   = 0;
    int xfer_cnt = 0;
    logic [7:0] exp_q [$];

    uart_key_tx_feeder #(.DATA_AMOUNT(DW), .FIFO_DEPTH(FD), .DB_CYCLES(DB)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .key_i        (key_i),
        .tx_ready_i   (tx_ready_i),
        .tx_valid_o   (tx_valid_o),
        .tx_data_o    (tx_data_o),
        .key_state_o  (key_state_o),
        .fifo_count_o (fifo_count_o),
        .ovf_o        (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    // Scoreboard: every accepted transfer must match the oldest expected byte.
    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && tx_valid_o && tx_ready_i) begin
                n_assert++;
                xfer_cnt++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_xfer: got byte %02h, required no transfer", tx_data_o);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (tx_data_o !== e) begin
                        n_fail++;
                        $display("FAIL xfer_byte: got %02h required %02h", tx_data_o, e);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic test_reset;
        int seen;
        rst_i = 1'b0; key_i = 4'hF; tx_ready_i = 1'b1;
        step(3);
        @(negedge clk_i);
        n_assert++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b required 0", tx_valid_o); end
        n_assert++; if (tx_data_o !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %02h required 00", tx_data_o); end
        n_assert++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL rst_count: got %0d required 0", fifo_count_o); end
        n_assert++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL rst_ovf: got %0b required 0", ovf_o); end
        n_assert++; if (key_state_o !== 4'hF) begin n_fail++; $display("FAIL rst_keystate: got %h required f", key_state_o); end
        step(1);
        rst_i = 1'b1;
        seen = 0;
        repeat (100) begin
            @(negedge clk_i);
            if (tx_valid_o) seen++;
        end
        n_assert++; if (seen !== 0) begin n_fail++; $display("FAIL idle_valid: got %0d valid cycles required 0", seen); end
        step(1);
    endtask

    task automatic test_single_press;
        int x0, lat;
        x0 = xfer_cnt; lat = 0;
        exp_q.push_back(8'h46);
        key_i[3] = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk_i);
            #1;
            if (tx_valid_o && lat == 0) lat = n;
        end
        key_i = 4'hF;
        step(30);
        n_assert++; if (lat !== DB + 4) begin n_fail++; $display("FAIL press_latency: got %0d edges required %0d", lat, DB + 4); end
        n_assert++; if (xfer_cnt - x0 !== 1) begin n_fail++; $display("FAIL press_xfers: got %0d required 1", xfer_cnt - x0); end
        n_assert++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL press_drain: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_glitch;
        int x0, bad;
        x0 = xfer_cnt; bad = 0;
        repeat (4) begin
            key_i[1] = 1'b0;
            repeat (5) begin step(1); if (key_state_o !== 4'hF) bad++; end
            key_i[1] = 1'b1;
            repeat (5) begin step(1); if (key_state_o !== 4'hF) bad++; end
        end
        step(20);
        n_assert++; if (bad !== 0) begin n_fail++; $display("FAIL glitch_keystate: got %0d bad cycles required 0", bad); end
        n_assert++; if (xfer_cnt - x0 !== 0) begin n_fail++; $display("FAIL glitch_xfers: got %0d required 0", xfer_cnt - x0); end
    endtask

    task automatic test_all_keys;
        int x0, ovf_seen;
        x0 = xfer_cnt; ovf_seen = 0;
        exp_q.push_back(8'h46); exp_q.push_back(8'h08);
        exp_q.push_back(8'h7F); exp_q.push_back(8'hFF);
        key_i = 4'h0;
        repeat (20) begin step(1); if (ovf_o) ovf_seen++; end
        key_i = 4'hF;
        repeat (30) begin step(1); if (ovf_o) ovf_seen++; end
        n_assert++; if (ovf_seen !== 0) begin n_fail++; $display("FAIL all_ovf: got %0d cycles set required 0", ovf_seen); end
        n_assert++; if (xfer_cnt - x0 !== 4) begin n_fail++; $display("FAIL all_xfers: got %0d required 4", xfer_cnt - x0); end
        n_assert++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL all_drain: got %0d left required 0", exp_q.size()); end
    endtask

    task automatic test_overflow;
        int x0, k;
        logic exp_ovf;
        logic [7:0] code;
        tx_ready_i = 1'b0;
        exp_ovf = 1'b0;
        for (int p = 0; p < 5; p++) begin
            k = (p % 2 == 0) ? 2 : 0;
            code = (k == 2) ? 8'h08 : 8'hFF;
            // Nothing drains while ready is low, so the queue mirrors FIFO occupancy.
            if (exp_q.size() < FD) exp_q.push_back(code);
            else exp_ovf = 1'b1;
            key_i[k] = 1'b0;
            step(15);
            key_i = 4'hF;
            step(15);
        end
        @(negedge clk_i);
        n_assert++; if (fifo_count_o !== 3'(FD)) begin n_fail++; $display("FAIL ovf_count: got %0d required %0d", fifo_count_o, FD); end
        n_assert++; if (ovf_o !== exp_ovf) begin n_fail++; $display("FAIL ovf_flag: got %0b required %0b", ovf_o, exp_ovf); end
        n_assert++; if (tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL ovf_hold_valid: got %0b required 1", tx_valid_o); end
        n_assert++; if (tx_data_o !== exp_q[0]) begin n_fail++; $display("FAIL ovf_hold_data: got %02h required %02h", tx_data_o, exp_q[0]); end
        step(1);
        x0 = xfer_cnt;
        tx_ready_i = 1'b1;
        step(20);
        n_assert++; if (xfer_cnt - x0 !== 4) begin n_fail++; $display("FAIL ovf_xfers: got %0d required 4", xfer_cnt - x0); end
        n_assert++; if (exp_q.size() !== 0) begin n_fail++; $display("FAIL ovf_drain: got %0d left required 0", exp_q.size()); end
        n_assert++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL ovf_empty: got %0d required 0", fifo_count_o); end
    endtask

    task automatic test_reset_mid;
        int x0;
        tx_ready_i = 1'b0;
        exp_q.push_back(8'h46); exp_q.push_back(8'h7F);
        key_i = 4'b0101;
        step(20);
        key_i = 4'hF;
        step(15);
        @(negedge clk_i);
        n_assert++; if (fifo_count_o !== 3'd2) begin n_fail++; $display("FAIL mid_count: got %0d required 2", fifo_count_o); end
        n_assert++; if (tx_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_valid: got %0b required 1", tx_valid_o); end
        step(1);
        rst_i = 1'b0;
        #1;
        n_assert++; if (tx_valid_o !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %0b required 0", tx_valid_o); end
        n_assert++; if (fifo_count_o !== 3'd0) begin n_fail++; $display("FAIL arst_count: got %0d required 0", fifo_count_o); end
        exp_q.delete();
        step(1);
        rst_i = 1'b1;
        tx_ready_i = 1'b1;
        x0 = xfer_cnt;
        step(50);
        n_assert++; if (xfer_cnt - x0 !== 0) begin n_fail++; $display("FAIL arst_stale: got %0d xfers required 0", xfer_cnt - x0); end
        n_assert++; if (ovf_o !== 1'b0) begin n_fail++; $display("FAIL arst_ovf: got %0b required 0", ovf_o); end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_glitch();
        test_all_keys();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
